// File: rtl/mux8_rr_arbiter_if.sv
// Handshake/bus bundle between the requesters and the 8-way round-robin arbiter.
interface mux8_rr_arbiter_if #(
  parameter int DW = 8
);
  logic [7:0]      req;
  logic [8*DW-1:0] din;
  logic [7:0]      gnt;
  logic [2:0]      sel;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic            busy;

  modport master (output req, din, input gnt, sel, dout, dout_valid, busy);
  modport slave  (input req, din, output gnt, sel, dout, dout_valid, busy);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// 8-way round-robin arbiter with burst limit driving a registered 8:1 data mux.
// A grant holds until its requester drops or MAX_BURST beats have been taken;
// on release the pointer moves past the old winner and re-arbitration happens
// in the same cycle, so back-to-back grants have no idle bubble.
module mux8_rr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux8_rr_arbiter_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // beats already taken in this grant; MAX_BURST<=16 so 0..15 fits in 4 bits
  localparam int CW = 4;

  state_t         state_q, state_d;
  logic [7:0]     gnt_q, gnt_d;
  logic [2:0]     sel_q, sel_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic           dv_q, dv_d;

  logic           beat, last_beat, release_gnt;
  logic [2:0]     arb_ptr, win;

  // First requester at or after p (mod 8); scanned downward so the nearest wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Next-state, arbitration and datapath decode
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    beat        = (state_q == GRANT) && bus.req[sel_q];
    last_beat   = beat && (cnt_q == CW'(MAX_BURST - 1));
    release_gnt = (state_q == GRANT) && (!bus.req[sel_q] || last_beat);
    // A releasing grant hands priority to the next index this same cycle
    arb_ptr     = release_gnt ? sel_q + 3'd1 : ptr_q;
    win         = rr_pick(bus.req, arb_ptr);

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = 8'b1 << win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          ptr_d = arb_ptr;
          cnt_d = '0;
          if (|bus.req) begin
            sel_d = win;
            gnt_d = 8'b1 << win;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    dv_d   = beat;
    dout_d = beat ? bus.din[sel_q*DW +: DW] : dout_q;
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.sel        = sel_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.busy       = (state_q == GRANT);
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: a table of per-cycle vectors plus
// hand-written sequences for bursts, contention, early drop, wrap and reset.
module tb_mux8_rr_arbiter;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errs   = 0;
  int   checks = 0;

  mux8_rr_arbiter_if #(.DW(DW)) bif ();

  mux8_rr_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       dv;
    logic [7:0] dout;
    logic       busy;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sel is only meaningful while a grant is held
  task automatic chk_out(input string tag, input logic [7:0] eg, input logic [2:0] es,
                         input logic edv, input logic [7:0] ed, input logic eb);
    chk({tag, ".gnt"}, int'(bif.gnt), int'(eg));
    if (eg != 8'h00) chk({tag, ".sel"}, int'(bif.sel), int'(es));
    chk({tag, ".dout_valid"}, int'(bif.dout_valid), int'(edv));
    chk({tag, ".dout"}, int'(bif.dout), int'(ed));
    chk({tag, ".busy"}, int'(bif.busy), int'(eb));
  endtask

  task automatic step(input logic r, input logic [7:0] q);
    rst_n   = r;
    bif.req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic din_default();
    for (int k = 0; k < 8; k++) bif.din[k*DW +: DW] = 8'hA0 + 8'(k);
  endtask

  task automatic do_reset(input logic [7:0] q);
    step(1'b0, q);
    step(1'b0, q);
  endtask

  // Safety net: never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    bif.req = '0;
    din_default();

    // rst, req,  gnt,  sel, dv, dout,  busy   (din slice k = A0+k)
    tbl[0]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 1'b1};
    tbl[3]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 8'hA0, 1'b1};
    tbl[4]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 8'hA0, 1'b1};
    tbl[5]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 8'hA0, 1'b1};
    tbl[6]  = '{1'b1, 8'hFF, 8'h02, 3'd1, 1'b1, 8'hA0, 1'b1};
    tbl[7]  = '{1'b1, 8'hFF, 8'h02, 3'd1, 1'b1, 8'hA1, 1'b1};
    tbl[8]  = '{1'b1, 8'hFF, 8'h02, 3'd1, 1'b1, 8'hA1, 1'b1};
    tbl[9]  = '{1'b1, 8'hFF, 8'h02, 3'd1, 1'b1, 8'hA1, 1'b1};
    tbl[10] = '{1'b1, 8'hFF, 8'h04, 3'd2, 1'b1, 8'hA1, 1'b1};
    tbl[11] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'hA1, 1'b0};
    tbl[12] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'hA1, 1'b0};
    tbl[13] = '{1'b1, 8'h05, 8'h01, 3'd0, 1'b0, 8'hA1, 1'b1};
    tbl[14] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'hA1, 1'b0};
    tbl[15] = '{1'b1, 8'h05, 8'h04, 3'd2, 1'b0, 8'hA1, 1'b1};
    tbl[16] = '{1'b1, 8'h05, 8'h04, 3'd2, 1'b1, 8'hA2, 1'b1};
    tbl[17] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b0, 8'hA2, 1'b1};
    tbl[18] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 8'hA0, 1'b1};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst_n, tbl[i].req);
      chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].dv,
              tbl[i].dout, tbl[i].busy);
    end

    // Full contention: grants 0..7 then 0 again, exactly MB cycles each
    do_reset(8'hFF);
    step(1'b1, 8'hFF);
    for (int g = 0; g < 9; g++) begin
      for (int b = 0; b < MB; b++) begin
        chk($sformatf("rr.g%0d.b%0d.gnt", g, b), int'(bif.gnt), 1 << (g % 8));
        chk($sformatf("rr.g%0d.b%0d.sel", g, b), int'(bif.sel), g % 8);
        if (!(g == 0 && b == 0))
          chk($sformatf("rr.g%0d.b%0d.dv", g, b), int'(bif.dout_valid), 1);
        step(1'b1, 8'hFF);
      end
    end

    // Single requester 5, slice5 carries the beat number; regrant is seamless
    do_reset(8'h20);
    step(1'b1, 8'h20);
    chk("solo.first.gnt", int'(bif.gnt), 8'h20);
    chk("solo.first.dv", int'(bif.dout_valid), 0);
    for (int n = 1; n <= 10; n++) begin
      bif.din[5*DW +: DW] = 8'(n);
      step(1'b1, 8'h20);
      chk($sformatf("solo.%0d.gnt", n), int'(bif.gnt), 8'h20);
      chk($sformatf("solo.%0d.sel", n), int'(bif.sel), 5);
      chk($sformatf("solo.%0d.dv", n), int'(bif.dout_valid), 1);
      chk($sformatf("solo.%0d.dout", n), int'(bif.dout), n);
    end
    din_default();

    // Early drop: 3 takes two beats, drops; pending 6 granted with no bubble
    do_reset(8'h08);
    step(1'b1, 8'h08);
    chk_out("drop.g3", 8'h08, 3'd3, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h48);
    chk_out("drop.b1", 8'h08, 3'd3, 1'b1, 8'hA3, 1'b1);
    step(1'b1, 8'h48);
    chk_out("drop.b2", 8'h08, 3'd3, 1'b1, 8'hA3, 1'b1);
    step(1'b1, 8'h40);
    chk_out("drop.rel", 8'h40, 3'd6, 1'b0, 8'hA3, 1'b1);
    step(1'b1, 8'h40);
    chk_out("drop.g6", 8'h40, 3'd6, 1'b1, 8'hA6, 1'b1);

    // Pointer wrap: release of 7 moves pointer to 0, so 0 beats 2
    do_reset(8'h80);
    step(1'b1, 8'h80);
    chk_out("wrap.g7", 8'h80, 3'd7, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h80);
    step(1'b1, 8'h05);
    chk_out("wrap.g0", 8'h01, 3'd0, 1'b0, 8'hA7, 1'b1);

    // Mid-burst reset aborts grant to 4; afterwards pointer is back at 0
    do_reset(8'h10);
    step(1'b1, 8'h10);
    step(1'b1, 8'h10);
    chk_out("mrst.b1", 8'h10, 3'd4, 1'b1, 8'hA4, 1'b1);
    step(1'b0, 8'h10);
    chk_out("mrst.rst", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    chk("mrst.rst.sel", int'(bif.sel), 0);
    step(1'b1, 8'h90);
    chk_out("mrst.after", 8'h10, 3'd4, 1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
